// File: rtl/time_set_controller.sv
// time_set_controller: BCD time-of-day keeper with 1 Hz run mode and button-driven field editing
//
// Owns the hh:mm:ss digits shown by the VGA text overlay. In RUN the time
// advances once every TICK_DIV clocks. Mode-button edges step through
// SET_HR -> SET_MIN -> SET_SEC -> RUN, and up/down edges adjust the selected
// field with wrap and no carry.
//
// Build option: define BLINK_EN to blink the edited field at BLINK_DIV clocks
// per phase; otherwise the edited field's mask bits are held steady.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   btn_mode, btn_up, btn_down      debounced level buttons, synchronous to clk
//   segundos_u/d, minutos_u/d,
//   horas_u/d                       BCD time digits (registered)
//   edit_field                      0=RUN, 1=hours, 2=minutes, 3=seconds
//   blink_mask                      per-digit blank flags {hr_d,hr_u,min_d,min_u,seg_d,seg_u}
//   tick_1hz                        one-cycle pulse on each run-mode second increment
module time_set_controller #(
    parameter int unsigned TICK_DIV  = 100000000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] segundos_u,
    output logic [3:0] segundos_d,
    output logic [3:0] minutos_u,
    output logic [3:0] minutos_d,
    output logic [3:0] horas_u,
    output logic [3:0] horas_d,
    output logic [1:0] edit_field,
    output logic [5:0] blink_mask,
    output logic       tick_1hz
);
    typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2, SET_SEC = 2'd3} state_t;
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    if (TICK_DIV < 4 || BLINK_DIV < 1) begin : g_bad_cfg
        $error("time_set_controller: TICK_DIV must be >= 4 and BLINK_DIV >= 1");
    end
    // Fields are kept as packed BCD pairs {tens, units}; wrap limits are BCD too.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        return (v == lim) ? 8'h00 :
               (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lim);
        return (v == 8'h00) ? lim :
               (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
    endfunction
    function automatic logic [5:0] field_bits(input state_t s);
        return (s == SET_HR)  ? 6'b110000 :
               (s == SET_MIN) ? 6'b001100 :
               (s == SET_SEC) ? 6'b000011 : 6'b000000;
    endfunction
    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    hr_q, hr_d, min_q, min_d, sec_q, sec_d;
    logic          mode_q, up_q, down_q;
    logic          tick_q;
    logic [5:0]    mask_q, mask_d;
    logic          mode_e, up_e, dn_e, adj, tick;
`ifdef BLINK_EN
    localparam int unsigned BW = $clog2(BLINK_DIV + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d, blink_clr, blink_wrap;
`endif
    always_comb begin
        mode_e  = btn_mode & ~mode_q;
        up_e    = btn_up & ~up_q;
        dn_e    = btn_down & ~down_q;
        // A mode edge takes priority; simultaneous up+down cancel out.
        adj     = ~mode_e & (up_e ^ dn_e);
        tick    = (state_q == RUN) && (pre_q == PRE_LAST);
        state_d = mode_e ? state_t'(state_q + 2'd1) : state_q;
        pre_d   = (state_q != RUN || tick) ? '0 : pre_q + 1'b1;
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        if (tick) begin
            sec_d = bcd_inc(sec_q, 8'h59);
            min_d = (sec_q == 8'h59) ? bcd_inc(min_q, 8'h59) : min_q;
            hr_d  = (sec_q == 8'h59 && min_q == 8'h59) ? bcd_inc(hr_q, 8'h23) : hr_q;
        end else if (adj) begin
            hr_d  = (state_q != SET_HR)  ? hr_q  : up_e ? bcd_inc(hr_q, 8'h23)  : bcd_dec(hr_q, 8'h23);
            min_d = (state_q != SET_MIN) ? min_q : up_e ? bcd_inc(min_q, 8'h59) : bcd_dec(min_q, 8'h59);
            sec_d = (state_q != SET_SEC) ? sec_q : up_e ? bcd_inc(sec_q, 8'h59) : bcd_dec(sec_q, 8'h59);
        end
`ifdef BLINK_EN
        // Restart the blink with the digit visible on field entry or any adjustment.
        blink_clr   = mode_e | up_e | dn_e | (state_d == RUN);
        blink_wrap  = blink_cnt_q == BLINK_LAST;
        blink_cnt_d = (blink_clr | blink_wrap) ? '0 : blink_cnt_q + 1'b1;
        phase_d     = ~blink_clr & (phase_q ^ blink_wrap);
        mask_d      = field_bits(state_d) & {6{phase_d}};
`else
        mask_d      = field_bits(state_d);
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pre_q       <= '0;
            hr_q        <= 8'h00;
            min_q       <= 8'h00;
            sec_q       <= 8'h00;
            mode_q      <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            tick_q      <= 1'b0;
            mask_q      <= 6'b0;
`ifdef BLINK_EN
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            hr_q        <= hr_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            mode_q      <= btn_mode;
            up_q        <= btn_up;
            down_q      <= btn_down;
            tick_q      <= tick;
            mask_q      <= mask_d;
`ifdef BLINK_EN
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
`endif
        end
    end
    assign segundos_u = sec_q[3:0];
    assign segundos_d = sec_q[7:4];
    assign minutos_u  = min_q[3:0];
    assign minutos_d  = min_q[7:4];
    assign horas_u    = hr_q[3:0];
    assign horas_d    = hr_q[7:4];
    assign edit_field = state_q;
    assign blink_mask = mask_q;
    assign tick_1hz   = tick_q;
endmodule

// File: tb/tb_time_set_controller.sv
// tb_time_set_controller: directed and random checks of time_set_controller against a seconds-of-day model
module tb_time_set_controller;
    localparam int TICK_DIV  = 10;
    localparam int BLINK_DIV = 4;
    logic clk = 1'b0, rst_n = 1'b0, btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic [3:0] su, sd, mu, md, hu, hd;
    logic [1:0] edit_field;
    logic [5:0] blink_mask;
    logic       tick_1hz;
    int vectors = 0, miscompares = 0;
    int hh, mm, ss, fld, pre;
    bit tk, pm, pu, pd;
`ifdef BLINK_EN
    int bcnt;
    bit ph;
`endif
    int ticks[$];
    int first_tick, hr_before;
    bit rm, ru, rd;
    time_set_controller #(.TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .segundos_u(su), .segundos_d(sd), .minutos_u(mu), .minutos_d(md), .horas_u(hu), .horas_d(hd),
        .edit_field(edit_field), .blink_mask(blink_mask), .tick_1hz(tick_1hz)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic model_reset();
        hh = 0; mm = 0; ss = 0; fld = 0; pre = 0; tk = 0; pm = 0; pu = 0; pd = 0;
`ifdef BLINK_EN
        bcnt = 0; ph = 0;
`endif
    endtask
    task automatic model_step(input bit m, input bit u, input bit d);
        bit me, ue, de;
        int t, dlt;
        me = m && !pm; ue = u && !pu; de = d && !pd;
        pm = m; pu = u; pd = d;
        tk = 0;
        if (fld == 0) begin
            if (pre == TICK_DIV - 1) begin
                pre = 0; tk = 1;
                t = (hh * 3600 + mm * 60 + ss + 1) % 86400;
                hh = t / 3600; mm = (t / 60) % 60; ss = t % 60;
            end else pre++;
        end else begin
            pre = 0;
            if (!me && ue != de) begin
                dlt = ue ? 1 : -1;
                if (fld == 1) hh = (hh + dlt + 24) % 24;
                else if (fld == 2) mm = (mm + dlt + 60) % 60;
                else ss = (ss + dlt + 60) % 60;
            end
        end
        if (me) fld = (fld + 1) % 4;
`ifdef BLINK_EN
        if (me || ue || de || fld == 0) begin bcnt = 0; ph = 0; end
        else if (bcnt == BLINK_DIV - 1) begin bcnt = 0; ph = !ph; end
        else bcnt++;
`endif
    endtask
    function automatic logic [31:0] exp_time();
        return 32'((hh / 10) << 20 | (hh % 10) << 16 | (mm / 10) << 12 | (mm % 10) << 8 | (ss / 10) << 4 | ss % 10);
    endfunction
    function automatic logic [31:0] exp_mask();
        int bits;
        bits = (fld == 0) ? 0 : 3 << (2 * (3 - fld));
`ifdef BLINK_EN
        return ph ? 32'(bits) : 32'd0;
`else
        return 32'(bits);
`endif
    endfunction
    task automatic check_all(input string tag);
        check({tag, ":time"}, {8'h0, hd, hu, md, mu, sd, su}, exp_time());
        check({tag, ":field"}, 32'(edit_field), 32'(fld));
        check({tag, ":tick"}, 32'(tick_1hz), 32'(tk));
        check({tag, ":mask"}, 32'(blink_mask), exp_mask());
    endtask
    task automatic step(input bit m, input bit u, input bit d, input string tag);
        btn_mode = m; btn_up = u; btn_down = d;
        @(posedge clk);
        model_step(m, u, d);
        #1 check_all(tag);
    endtask
    task automatic press(input bit m, input bit u, input bit d, input string tag);
        step(m, u, d, tag);
        step(0, 0, 0, tag);
    endtask
    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all("reset");
        rst_n = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step(0, 0, 0, "run");
            if (tick_1hz) ticks.push_back(i);
        end
        check("tick_count", 32'(ticks.size()), 32'd3);
        for (int k = 0; k < 3; k++) check("tick_pos", 32'(k < ticks.size() ? ticks[k] : 0), 32'(10 * (k + 1)));
        check("sec_after_30", {24'h0, sd, su}, 32'h03);
        press(1, 0, 0, "to_hr");
        check("field_hr", 32'(edit_field), 32'd1);
        press(0, 0, 1, "hr_dn");
        check("hr_wrap_dn", {24'h0, hd, hu}, 32'h23);
        press(0, 1, 0, "hr_up");
        press(0, 1, 0, "hr_up");
        check("hr_wrap_up2", {24'h0, hd, hu}, 32'h01);
        for (int i = 0; i < 24 && hh != 23; i++) press(0, 0, 1, "hr_dn");
        press(1, 0, 0, "to_min");
        for (int i = 0; i < 60 && mm != 59; i++) press(0, 0, 1, "min_dn");
        press(0, 1, 0, "min_up");
        check("min_wrap_up", {16'h0, hd, hu, md, mu}, 32'h2300);
        press(0, 0, 1, "min_dn");
        press(1, 0, 0, "to_sec");
        for (int i = 0; i < 60 && ss != 0; i++) press(0, 0, 1, "sec_dn");
        press(0, 0, 1, "sec_dn");
        check("sec_wrap_dn", {24'h0, sd, su}, 32'h59);
        press(0, 1, 1, "up_dn");
        check("up_dn_cancel", {24'h0, sd, su}, 32'h59);
        for (int i = 0; i < 50; i++) step(0, 1, 0, "hold_up");
        step(0, 0, 0, "hold_up");
        check("hold_single", {24'h0, sd, su}, 32'h00);
        press(0, 0, 1, "sec_dn");
        press(0, 0, 1, "sec_dn");
        check("preload", {8'h0, hd, hu, md, mu, sd, su}, 32'h235958);
        step(1, 0, 0, "to_run");
        first_tick = 0;
        for (int i = 1; i <= 2 * TICK_DIV && first_tick == 0; i++) begin
            step(0, 0, 0, "run2");
            if (tick_1hz) first_tick = i;
        end
        check("restart_tick", 32'(first_tick), 32'(TICK_DIV));
        check("t_235959", {8'h0, hd, hu, md, mu, sd, su}, 32'h235959);
        for (int i = 0; i < TICK_DIV; i++) step(0, 0, 0, "run3");
        check("rollover", {8'h0, hd, hu, md, mu, sd, su, 3'b0, tick_1hz}, 32'h0000_0001);
        step(1, 0, 0, "blink_entry");
        for (int k = 0; k < 14; k++) begin
            if (k > 0) step(0, 0, 0, "blink");
`ifdef BLINK_EN
            check("blink_phase", 32'(blink_mask), ((k / BLINK_DIV) % 2) ? 32'h30 : 32'h0);
`else
            check("blink_steady", 32'(blink_mask), 32'h30);
`endif
        end
        step(0, 1, 0, "blink_up");
`ifdef BLINK_EN
        check("blink_up_clear", 32'(blink_mask), 32'h0);
`else
        check("blink_up_steady", 32'(blink_mask), 32'h30);
`endif
        step(0, 0, 0, "blink_up");
        hr_before = hh;
        step(1, 1, 0, "mode_up");
        check("mode_wins_field", 32'(edit_field), 32'd2);
        check("mode_wins_hr", {24'h0, hd, hu}, 32'((hr_before / 10) << 4 | hr_before % 10));
        step(0, 0, 0, "mode_up");
        press(0, 1, 0, "min_up");
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        check("async_rst_field", 32'(edit_field), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rm = 0; ru = 0; rd = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) rm = !rm;
            if ($urandom_range(0, 3) == 0) ru = !ru;
            if ($urandom_range(0, 3) == 0) rd = !rd;
            step(rm, ru, rd, "rand");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
- Owns the time-of-day state displayed by the VGA text overlay: hours, minutes and seconds as six BCD digits.
- Sequences the 1 Hz run-time count and a user edit mode (mode/up/down buttons) that selects and adjusts one field at a time.
- Drives per-digit blink flags so the overlay can highlight the field being edited.
- Sits between the debounced button block and the character-address/overlay logic; all outputs are registered.

Parameters:
TICK_DIV, 100000000, clk cycles per second tick (>=4, even); benches override with small values
BLINK_DIV, 25000000, clk cycles per blink phase toggle (BLINK_EN builds only; >=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
btn_mode  input  1  mode button, level, debounced, synchronous to clk
btn_up  input  1  increment button, level, debounced, synchronous
btn_down  input  1  decrement button, level, debounced, synchronous
segundos_u  output  4  seconds units BCD
segundos_d  output  4  seconds tens BCD (0-5)
minutos_u  output  4  minutes units BCD
minutos_d  output  4  minutes tens BCD (0-5)
horas_u  output  4  hours units BCD
horas_d  output  4  hours tens BCD (0-2)
edit_field  output  2  0=RUN, 1=hours, 2=minutes, 3=seconds
blink_mask  output  6  bit0 seg_u, bit1 seg_d, bit2 min_u, bit3 min_d, bit4 hr_u, bit5 hr_d; 1=blank this digit now
tick_1hz  output  1  one-cycle pulse on each run-mode second increment

Behaviour:
- Reset (rst_n=0, async, takes effect immediately): time 00:00:00, state RUN, prescaler 0, btn history regs 0, tick_1hz 0, edit_field 0, blink_mask 0, blink phase 0.
- Button edges: each button has a registered previous value; an edge is btn=1 at a clock edge with history=0. Action takes effect at that same edge, so it is visible on outputs the cycle after the button is first sampled high. Holding a button gives exactly one action.
- FSM RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN, advancing on each btn_mode edge. edit_field reflects the state, registered with it.
- RUN: the prescaler counts 0..TICK_DIV-1. At the edge where it equals TICK_DIV-1, it returns to 0, tick_1hz<=1 for one cycle, and seconds increment. tick_1hz and the new digits are visible in the same cycle.
  - First tick after reset release: at the TICK_DIV-th edge.
  - Carry chain: sec 59->00 increments min; min 59->00 increments hr; 23:59:59 -> 00:00:00.
  - btn_up and btn_down are ignored.
- SET_*: the prescaler is held at 0 and tick_1hz stays 0.
  - btn_up edge: increment the selected field with wrap (hr 23->00, min/sec 59->00). No carry into other fields.
  - btn_down edge: decrement with wrap (hr 00->23, min/sec 00->59).
  - up and down edges in the same cycle: no change.
- Mode edge coincident with up/down edge: the mode transition wins and up/down is ignored that cycle.
- Leaving SET_SEC for RUN: the prescaler restarts from 0, so the next tick is TICK_DIV cycles later.
- Fields are always held as valid BCD. Tens/units update atomically in one cycle, with no intermediate illegal value (e.g. never 0x0A).
- blink_mask is 0 in RUN in all builds.

Optional Feature:
Macro BLINK_EN.
- Defined:
  - A blink counter runs in SET_* states only and toggles the blink phase every BLINK_DIV cycles.
  - blink_mask = selected field's two bits AND phase: hours 110000, minutes 001100, seconds 000011.
  - On entry to any SET_* state (including field-to-field), the counter and phase clear to 0, so the digit is shown first.
  - Any up/down edge also clears the counter and phase, so the new value is shown immediately.
- Not defined:
  - No blink counter is built.
  - blink_mask = selected field's two bits, held steady while in SET_*; 0 in RUN.

Test Plan:
- TICK_DIV=10: release reset, run 30 cycles -> tick_1hz pulses at cycles 10, 20, 30; seconds read 1, 2, 3; edit_field=0.
- Preload 23:59:58 via SET mode, return to RUN, wait 2 ticks -> 23:59:59 then 00:00:00 on the second tick.
- Mode edge -> edit_field=1. Down edge -> hr 23. Up x2 -> 01. Mode, mode, mode -> RUN, edit_field=0, next tick after exactly TICK_DIV cycles.
- SET_MIN at 59, up -> 00 with hours unchanged. SET_SEC at 00, down -> 59. Simultaneous up+down -> no change. btn_up held 50 cycles -> single increment.
- Mode and up edges in the same cycle from SET_HR -> edit_field=2, hours unchanged. Assert rst_n low mid-SET_MIN -> all outputs reset immediately, RUN.
- BLINK_EN, BLINK_DIV=4, SET_HR entry -> blink_mask 000000 for 4 cycles, 110000 for 4, alternating. Up edge -> mask 000000 next cycle. Without macro -> steady 110000.
